// File: rtl/instr_decode_if.sv
// instr_decode_if: handshake and decoded-field bundle around instr_decode_stage.
//   in_valid/in_ready/in_instr   : raw instruction stream from fetch (master drives valid/instr)
//   out_valid/out_ready/out_*    : decoded fields toward register read (slave drives valid/fields)
//   Modports: master = upstream/downstream environment, slave = decode stage.
interface instr_decode_if #(
  parameter int unsigned WIDTH__INSTR     = 32,
  parameter int unsigned WIDTH__REG_INDEX = 4,
  parameter int unsigned WIDTH__DATA      = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH__INSTR-1:0]     in_instr;
  logic                        out_valid;
  logic                        out_ready;
  logic [3:0]                  out_group;
  logic [WIDTH__REG_INDEX-1:0] out_ra_index;
  logic [WIDTH__REG_INDEX-1:0] out_rb_index;
  logic [WIDTH__REG_INDEX-1:0] out_rc_index;
  logic [3:0]                  out_opcode;
  logic [WIDTH__DATA-1:0]      out_imm;
  logic                        out_illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_group, out_ra_index, out_rb_index,
           out_rc_index, out_opcode, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_group, out_ra_index, out_rb_index,
           out_rc_index, out_opcode, out_imm, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered Frost32 decode stage with a two-entry skid buffer.
// Splits raw instruction words into group / ra / rb / rc / opcode / immediate and
// flags illegal encodings. in_ready is registered; flush drops every held entry.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous discard of all held instructions (highest priority)
//   io         : instr_decode_if.slave (in_* handshake from fetch, out_* toward register read)
// Optional feature: define FROST32_DECODE_STRICT_EN to also flag nonzero fill in
// groups 0/2/3 and opcodes above each group's highest defined opcode.
module instr_decode_stage #(
  parameter int unsigned WIDTH__INSTR     = 32,
  parameter int unsigned WIDTH__REG_INDEX = 4,
  parameter int unsigned WIDTH__DATA      = 32
) (
  input logic         clk,
  input logic         rst_n,
  input logic         flush,
  instr_decode_if.slave io
);

  localparam int unsigned WIDTH__GROUP = 4;
  localparam int unsigned WIDTH__OPER  = 4;
  localparam int          FILL_SIGNED  = int'(WIDTH__INSTR) - 8 - 3 * int'(WIDTH__REG_INDEX);
  localparam int unsigned WIDTH__IMM   = WIDTH__INSTR - 8 - 2 * WIDTH__REG_INDEX;
  localparam int unsigned POS_RA_LSB   = WIDTH__INSTR - WIDTH__GROUP - WIDTH__REG_INDEX;
  localparam int unsigned POS_RB_LSB   = POS_RA_LSB - WIDTH__REG_INDEX;
  localparam int unsigned POS_RC_LSB   = POS_RB_LSB - WIDTH__REG_INDEX;

  // Reject parameter sets whose fields cannot fit the instruction or data word
  if (FILL_SIGNED < 0 || WIDTH__IMM > WIDTH__DATA) begin : g_bad_cfg
    $error("instr_decode_stage: invalid WIDTH__INSTR/WIDTH__REG_INDEX/WIDTH__DATA combination");
  end

  typedef struct packed {
    logic [WIDTH__GROUP-1:0]     group;
    logic [WIDTH__REG_INDEX-1:0] ra;
    logic [WIDTH__REG_INDEX-1:0] rb;
    logic [WIDTH__REG_INDEX-1:0] rc;
    logic [WIDTH__OPER-1:0]      opcode;
    logic [WIDTH__DATA-1:0]      imm;
    logic                        illegal;
  } dec_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,   // {skid_valid, out_valid}
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_e;

`ifdef FROST32_DECODE_STRICT_EN
  localparam logic [WIDTH__OPER-1:0] OPC_MAX_G0 = 4'hf;
  localparam logic [WIDTH__OPER-1:0] OPC_MAX_G1 = 4'hf;
  localparam logic [WIDTH__OPER-1:0] OPC_MAX_G2 = 4'h3;
  localparam logic [WIDTH__OPER-1:0] OPC_MAX_G3 = 4'h5;
  localparam int unsigned WIDTH__FILL = (FILL_SIGNED < 0) ? 0 : unsigned'(FILL_SIGNED);
  localparam logic [WIDTH__INSTR-1:0] FILL_MASK =
    WIDTH__INSTR'(((64'd1 << WIDTH__FILL) - 64'd1) << WIDTH__OPER);

  logic fill_nz_c;
  assign fill_nz_c = |(io.in_instr & FILL_MASK);

  // Widened compare keeps "above the maximum" well-defined for a full-range limit
  function automatic logic opc_over(input logic [WIDTH__OPER-1:0] opc,
                                    input logic [WIDTH__OPER-1:0] lim);
    return {1'b0, opc} > {1'b0, lim};
  endfunction
`endif

  dec_t                  dec_c;
  logic [WIDTH__IMM-1:0] imm_raw;

  assign imm_raw = io.in_instr[WIDTH__IMM-1:0];

  // Combinational field split of the incoming word
  always_comb begin
    dec_c       = '0;
    dec_c.group = io.in_instr[WIDTH__INSTR-1 -: WIDTH__GROUP];
    dec_c.ra    = io.in_instr[POS_RA_LSB +: WIDTH__REG_INDEX];
    dec_c.rb    = io.in_instr[POS_RB_LSB +: WIDTH__REG_INDEX];
    if (dec_c.group == 4'd1) begin
      dec_c.opcode = io.in_instr[WIDTH__IMM +: WIDTH__OPER];
      dec_c.imm    = dec_c.opcode[3] ? WIDTH__DATA'($signed(imm_raw))
                                     : WIDTH__DATA'(imm_raw);
    end else begin
      dec_c.rc     = io.in_instr[POS_RC_LSB +: WIDTH__REG_INDEX];
      dec_c.opcode = io.in_instr[WIDTH__OPER-1:0];
    end
    dec_c.illegal = (dec_c.group > 4'd3);
`ifdef FROST32_DECODE_STRICT_EN
    case (dec_c.group)
      4'd0:    dec_c.illegal = fill_nz_c | opc_over(dec_c.opcode, OPC_MAX_G0);
      4'd1:    dec_c.illegal = opc_over(dec_c.opcode, OPC_MAX_G1);
      4'd2:    dec_c.illegal = fill_nz_c | opc_over(dec_c.opcode, OPC_MAX_G2);
      4'd3:    dec_c.illegal = fill_nz_c | opc_over(dec_c.opcode, OPC_MAX_G3);
      default: dec_c.illegal = 1'b1;
    endcase
`endif
  end

  state_e state_q, state_d;
  dec_t   main_q, main_d;
  dec_t   skid_q, skid_d;
  logic   in_ready_q;
  logic   accept_c;

  assign accept_c = io.in_valid & in_ready_q;

  // Next-state and storage steering; flush overrides every other event
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_c) begin
            main_d  = dec_c;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (accept_c && io.out_ready) begin
            main_d = dec_c;
          end else if (accept_c) begin
            skid_d  = dec_c;
            state_d = FULL;
          end else if (io.out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (io.out_ready) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign io.in_ready     = in_ready_q;
  assign io.out_valid    = state_q[0];
  assign io.out_group    = main_q.group;
  assign io.out_ra_index = main_q.ra;
  assign io.out_rb_index = main_q.rb;
  assign io.out_rc_index = main_q.rc;
  assign io.out_opcode   = main_q.opcode;
  assign io.out_imm      = main_q.imm;
  assign io.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: scoreboard bench for instr_decode_stage.
// Stimulus pushes expected decodes (from a field-arithmetic model) on accept; a
// negedge monitor pops and compares on every transfer and checks occupancy.
// Honours FROST32_DECODE_STRICT_EN for the expected illegal flag.
module tb_instr_decode_stage;

  localparam int unsigned WI = 32;
  localparam int unsigned WR = 4;
  localparam int unsigned WD = 32;
`ifdef FROST32_DECODE_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  instr_decode_if #(.WIDTH__INSTR(WI), .WIDTH__REG_INDEX(WR), .WIDTH__DATA(WD)) dif ();

  instr_decode_stage #(.WIDTH__INSTR(WI), .WIDTH__REG_INDEX(WR), .WIDTH__DATA(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  group;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [3:0]  opcode;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference decode from the field layout using shifts and masks
  function automatic exp_t model(input logic [31:0] w);
    exp_t        e;
    int unsigned u, imm16, fill;
    int          lim[4];
    lim = '{15, 15, 3, 5};
    u = w;
    e.group = 4'((u >> 28) & 15);
    e.ra    = 4'((u >> 24) & 15);
    e.rb    = 4'((u >> 20) & 15);
    if (e.group == 4'd1) begin
      e.rc     = 4'd0;
      e.opcode = 4'((u >> 16) & 15);
      imm16    = u & 32'hFFFF;
      if (e.opcode >= 4'd8 && imm16 >= 32768) e.imm = imm16 + 32'hFFFF_0000;
      else                                    e.imm = imm16;
    end else begin
      e.rc     = 4'((u >> 16) & 15);
      e.opcode = 4'(u & 15);
      e.imm    = 32'd0;
    end
    e.illegal = (e.group > 4'd3);
    if (STRICT && e.group <= 4'd3) begin
      fill = (u >> 4) & 32'hFFF;
      if (e.group != 4'd1 && fill != 0) e.illegal = 1'b1;
      if (int'(e.opcode) > lim[e.group]) e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold in_valid until the registered in_ready shows acceptance
  task automatic push_one(input logic [31:0] w);
    int budget = 50;
    dif.in_valid = 1'b1;
    dif.in_instr = w;
    while (!dif.in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stuck low for instr %h", w);
    end
    tick();
    dif.in_valid = 1'b0;
  endtask

  // Monitor: occupancy, holding stability, ordered scoreboard compare
  logic hold_q = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      hold_q = 1'b0;
    end else begin
      chk("occ_out_valid", 32'(dif.out_valid), 32'(sb.size() > 0));
      chk("occ_in_ready", 32'(dif.in_ready), 32'(sb.size() < 2));
      if (hold_q) begin
        chk("hold_group", 32'(dif.out_group), 32'(held.group));
        chk("hold_ra", 32'(dif.out_ra_index), 32'(held.ra));
        chk("hold_imm", dif.out_imm, held.imm);
        chk("hold_opcode", 32'(dif.out_opcode), 32'(held.opcode));
      end
      hold_q       = dif.out_valid && !dif.out_ready && !flush;
      held.group   = dif.out_group;
      held.ra      = dif.out_ra_index;
      held.imm     = dif.out_imm;
      held.opcode  = dif.out_opcode;
      if (flush) begin
        sb.delete();
      end else begin
        if (dif.out_valid && dif.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: transfer with empty scoreboard, group %h ra %h",
                     dif.out_group, dif.out_ra_index);
          end else begin
            e = sb.pop_front();
            chk("sb_group", 32'(dif.out_group), 32'(e.group));
            chk("sb_ra", 32'(dif.out_ra_index), 32'(e.ra));
            chk("sb_rb", 32'(dif.out_rb_index), 32'(e.rb));
            chk("sb_rc", 32'(dif.out_rc_index), 32'(e.rc));
            chk("sb_opcode", 32'(dif.out_opcode), 32'(e.opcode));
            chk("sb_imm", dif.out_imm, e.imm);
            chk("sb_illegal", 32'(dif.out_illegal), 32'(e.illegal));
          end
        end
        if (dif.in_valid && dif.in_ready) sb.push_back(model(dif.in_instr));
      end
    end
  end

  logic [31:0] bp[4];

  initial begin
    int idx;
    int budget;
    logic acc;
    logic [31:0] low;
    logic [3:0]  grp;

    dif.in_valid  = 1'b0;
    dif.in_instr  = '0;
    dif.out_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("rst_group", 32'(dif.out_group), 32'd0);
    chk("rst_ra", 32'(dif.out_ra_index), 32'd0);
    chk("rst_opcode", 32'(dif.out_opcode), 32'd0);
    chk("rst_imm", dif.out_imm, 32'd0);
    chk("rst_illegal", 32'(dif.out_illegal), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic decode, one-cycle latency
    dif.out_ready = 1'b1;
    push_one(32'h0123_0005);
    chk("d0_valid", 32'(dif.out_valid), 32'd1);
    chk("d0_group", 32'(dif.out_group), 32'd0);
    chk("d0_ra", 32'(dif.out_ra_index), 32'd1);
    chk("d0_rb", 32'(dif.out_rb_index), 32'd2);
    chk("d0_rc", 32'(dif.out_rc_index), 32'd3);
    chk("d0_opcode", 32'(dif.out_opcode), 32'd5);
    chk("d0_illegal", 32'(dif.out_illegal), 32'd0);

    // Immediate extension
    push_one(32'h1128_8000);
    chk("g1_sext_imm", dif.out_imm, 32'hFFFF_8000);
    chk("g1_sext_opcode", 32'(dif.out_opcode), 32'd8);
    chk("g1_rc", 32'(dif.out_rc_index), 32'd0);
    push_one(32'h1120_8000);
    chk("g1_zext_imm", dif.out_imm, 32'h0000_8000);

    // Illegal encodings
    push_one(32'h5123_0005);
    chk("ill_group5", 32'(dif.out_illegal), 32'd1);
    push_one(32'h0123_0105);
    chk("ill_fill", 32'(dif.out_illegal), 32'(STRICT));
    repeat (3) tick();

    // Backpressure: fill main and skid, then drain in order
    bp = '{32'h0100_0001, 32'h0200_0002, 32'h0300_0003, 32'h0400_0004};
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    idx = 0;
    for (int c = 1; c <= 4; c++) begin
      dif.in_instr = bp[idx];
      acc = dif.in_ready;
      if (c <= 2) chk("bp_in_ready_early", 32'(dif.in_ready), 32'd1);
      else        chk("bp_in_ready_full", 32'(dif.in_ready), 32'd0);
      if (c >= 2) chk("bp_head_ra", 32'(dif.out_ra_index), 32'd1);
      tick();
      if (acc) idx++;
    end
    dif.out_ready = 1'b1;
    budget = 20;
    while (idx < 4 && budget > 0) begin
      dif.in_instr = bp[idx];
      acc = dif.in_ready;
      tick();
      if (acc) idx++;
      budget--;
    end
    chk("bp_all_accepted", 32'(idx), 32'd4);
    dif.in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Flush while FULL with a simultaneous input
    dif.out_ready = 1'b0;
    push_one(32'h0A00_0001);
    push_one(32'h0B00_0002);
    chk("fl_full_in_ready", 32'(dif.in_ready), 32'd0);
    flush         = 1'b1;
    dif.in_valid  = 1'b1;
    dif.in_instr  = 32'h0C00_0003;
    dif.out_ready = 1'b1;
    tick();
    flush        = 1'b0;
    dif.in_valid = 1'b0;
    chk("fl_out_valid", 32'(dif.out_valid), 32'd0);
    chk("fl_in_ready", 32'(dif.in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_no_ghost", 32'(dif.out_valid), 32'd0);
    end

    // Asynchronous reset while FULL
    dif.out_ready = 1'b0;
    push_one(32'h0D00_0001);
    push_one(32'h0E00_0002);
    chk("ar_full_valid", 32'(dif.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid_now", 32'(dif.out_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("ar_in_ready", 32'(dif.in_ready), 32'd1);
    tick();

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      grp = 4'($urandom_range(0, 5));
      low = $urandom;
      if (($urandom % 2) == 0) low = low & 32'hFFFF_000F;
      dif.in_instr  = {grp, low[27:0]};
      dif.in_valid  = (($urandom % 10) < 7);
      dif.out_ready = (($urandom % 10) < 6);
      flush         = (($urandom % 50) == 0);
      tick();
    end
    dif.in_valid  = 1'b0;
    flush         = 1'b0;
    dif.out_ready = 1'b1;
    repeat (5) tick();
    chk("end_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
